alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the datapath width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port x, input, WIDTH bits: operand X.
REQ-005 The block SHALL have port y, input, WIDTH bits: operand Y.
REQ-006 The block SHALL have ports zx, nx, zy, ny, f, no, each input, 1 bit, with the Hack ALU control meanings.
REQ-007 The block SHALL have port mul, input, 1 bit: when 1, f is ignored and the core op is multiply.
REQ-008 The block SHALL have port in_valid, input, 1 bit: operands and controls are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-010 The block SHALL have port out, output, WIDTH bits: registered result.
REQ-011 The block SHALL have ports zr, ng, cy, ov, each output, 1 bit: registered flags for out.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out and the flags are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-014 Operands and controls SHALL be captured only on an edge where in_valid and in_ready are both 1 (accept); inputs at any other time are ignored.
REQ-015 Pre-processing SHALL be x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1; y2 is formed likewise from y, zy and ny.
REQ-016 The core result F SHALL be x2 & y2 if mul=0 and f=0, (x2 + y2) mod 2^WIDTH if mul=0 and f=1, and the low WIDTH bits of the unsigned product x2 * y2 if mul=1.
REQ-017 The output SHALL be out = no ? ~F : F.
REQ-018 zr SHALL equal (out == 0), and ng SHALL equal out[WIDTH-1].
REQ-019 cy SHALL be the carry out of bit WIDTH-1 of x2 + y2 for an add, and 0 otherwise.
REQ-020 ov SHALL be signed two's-complement overflow of x2 + y2 for an add, and 0 otherwise.
REQ-021 cy and ov SHALL NOT be affected by no.
REQ-022 The FSM SHALL have states IDLE, MUL, HOLD.
REQ-023 In IDLE, in_ready SHALL be 1 iff out_valid = 0 or out_ready = 1.
REQ-024 In MUL and HOLD, in_ready SHALL be 0.
REQ-025 An accept with mul=0 SHALL register the result and flags on the same edge, so out_valid = 1 one cycle after accept; the state stays IDLE.
REQ-026 An accept with mul=1 SHALL move the state IDLE->MUL and load the multiplicand, the multiplier and a zero accumulator, with a counter of WIDTH.
REQ-027 In MUL, each edge SHALL perform one shift-add step (add the multiplicand if multiplier bit 0 is 1, shift the multiplicand left, shift the multiplier right) and decrement the counter.
REQ-028 On the WIDTH-th MUL edge the result and flags SHALL be registered, out_valid set to 1, and the state SHALL go to HOLD; total latency is WIDTH cycles after accept.
REQ-029 In HOLD, on an edge with out_ready = 1, the state SHALL go to IDLE.
REQ-030 An accepted operation SHALL NOT overwrite an unconsumed result.
REQ-031 out_valid SHALL clear on an edge with out_ready = 1 unless a new mul=0 result is registered on the same edge, in which case it stays 1 with the new data (back-to-back, one result per cycle).
REQ-032 While out_valid = 1 and out_ready = 0, out, zr, ng, cy and ov SHALL be held stable.
REQ-033 A multiply with x2 = 0 or y2 = 0 SHALL still take WIDTH cycles.
REQ-034 Multiply overflow beyond WIDTH bits SHALL be discarded silently.

Reset
REQ-035 When rst_n = 0 at an edge, the state SHALL go to IDLE; out, zr, ng, cy, ov, out_valid and the counter SHALL be 0; and zr SHALL be 1.
REQ-036 A reset during MUL or HOLD SHALL abort the operation with no output produced.
REQ-037 in_ready SHALL be 1 on the first edge after rst_n returns to 1.

Verification (WIDTH=16)
REQ-038 Scenario add: x=5, y=3, all controls 0 except f=1, out_ready=1 -> next cycle out=0x0008, zr=0, ng=0, cy=0, ov=0.
REQ-039 Scenario constant -1: zx=nx=zy=1, ny=0, f=1, no=0 -> out=0xFFFF, ng=1, zr=0; and zx=zy=1, f=0 -> out=0x0000, zr=1.
REQ-040 Scenario overflow: x=0x7FFF, y=0x0001, f=1 -> out=0x8000, ov=1, ng=1, cy=0; then x=0xFFFF, y=0x0001 -> out=0x0000, cy=1, zr=1, ov=0.
REQ-041 Scenario multiply: x=7, y=6, mul=1 -> in_ready=0 for 16 cycles, out=0x002A exactly 16 cycles after accept; then x=0x0100, y=0x0100 -> out=0x0000, zr=1.
REQ-042 Scenario backpressure: out_ready=0 after an add result -> out, flags and out_valid held for 5 cycles and in_ready=0; then out_ready=1 with an add pending -> the new result appears the next cycle with no gap.
REQ-043 Scenario reset mid-multiply: rst_n=0 at cycle 8 of a multiply -> out_valid=0, out=0, zr=1, in_ready=1 after release, and no stale result appears.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: Hack-style ALU with a sequential shift-add multiplier and a
// valid/ready handshake on both sides.
//
// Parameters
//   WIDTH      datapath width in bits (2..64)
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   x, y       operands
//   zx,nx      zero / invert X before the core op
//   zy,ny      zero / invert Y before the core op
//   f          core op select when mul=0: 0 = AND, 1 = ADD
//   no         invert the core result
//   mul        1 = multiply (f ignored), takes WIDTH cycles
//   in_valid   operands and controls are valid
//   in_ready   an operation can be accepted this cycle
//   out        registered result
//   zr,ng      registered zero / negative flags of out
//   cy,ov      registered carry / signed overflow of an add (0 otherwise)
//   out_valid  out and flags are valid
//   out_ready  consumer takes the result this cycle
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic             no_q;

  logic [WIDTH-1:0] x1, x2, y1, y2;
  logic [WIDTH:0]   sum;
  logic             add_cy, add_ov;
  logic [WIDTH-1:0] core, comb_res;
  logic [WIDTH-1:0] mul_step, mul_res;
  logic             accept, mul_done;

  // Operand pre-processing, single-cycle AND/ADD result and add flags.
  always_comb begin
    x1 = zx ? {WIDTH{1'b0}} : x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? {WIDTH{1'b0}} : y;
    y2 = ny ? ~y1 : y1;
    sum = {1'b0, x2} + {1'b0, y2};
    add_cy = sum[WIDTH];
    // Signed overflow: operands share a sign that the sum does not.
    add_ov = (x2[WIDTH-1] == y2[WIDTH-1]) && (sum[WIDTH-1] != x2[WIDTH-1]);
    core = f ? sum[WIDTH-1:0] : (x2 & y2);
    comb_res = no ? ~core : core;
  end

  // Multiply step: accumulator value after the current shift-add step.
  always_comb begin
    mul_step = acc + (mplier[0] ? mcand : {WIDTH{1'b0}});
    mul_res = no_q ? ~mul_step : mul_step;
  end

  // Handshake decode.
  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
    accept = in_valid && in_ready;
    mul_done = (state == MUL) && (cnt == CW'(1));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && mul) state_nxt = MUL;
        else state_nxt = IDLE;
      end
      MUL: begin
        if (cnt == CW'(1)) state_nxt = HOLD;
        else state_nxt = MUL;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
        else state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // Datapath: result/flag registers, multiplier working registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= {WIDTH{1'b0}};
      zr        <= 1'b1;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= {CW{1'b0}};
      mcand     <= {WIDTH{1'b0}};
      mplier    <= {WIDTH{1'b0}};
      acc       <= {WIDTH{1'b0}};
      no_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && mul) begin
            // Any previous result is consumed on this edge (in_ready held).
            mcand     <= x2;
            mplier    <= y2;
            acc       <= {WIDTH{1'b0}};
            cnt       <= CW'(WIDTH);
            no_q      <= no;
            out_valid <= 1'b0;
          end else if (accept) begin
            out       <= comb_res;
            zr        <= (comb_res == {WIDTH{1'b0}});
            ng        <= comb_res[WIDTH-1];
            cy        <= f & add_cy;
            ov        <= f & add_ov;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= mul_step;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (mul_done) begin
            out       <= mul_res;
            zr        <= (mul_res == {WIDTH{1'b0}});
            ng        <= mul_res[WIDTH-1];
            cy        <= 1'b0;
            ov        <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
